// File: rtl/if_else_stmt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_else_defs (package)
// Purpose  : Shared operator/error/state codes and segment text for the
//            if/else statement generator and its companion parser.
// Revision : 1.0 - initial release
// ============================================================================
package if_else_defs;

    localparam int c_MAX_VAR_LEN  = 16;
    localparam int c_CHAR_W       = 7;
    localparam int c_NUM_W        = 32;
    localparam int c_BCD_DIGITS   = 10;

    localparam logic [2:0] c_OP_GT = 3'd0;
    localparam logic [2:0] c_OP_LT = 3'd1;
    localparam logic [2:0] c_OP_GE = 3'd2;
    localparam logic [2:0] c_OP_LE = 3'd3;
    localparam logic [2:0] c_OP_EQ = 3'd4;
    localparam logic [2:0] c_OP_NE = 3'd5;

    localparam logic [3:0] c_ERR_NONE = 4'd0;
    localparam logic [3:0] c_ERR_LEN  = 4'd1;
    localparam logic [3:0] c_ERR_OP   = 4'd2;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_EMIT  = 3'd2;
    localparam logic [2:0] c_ST_CONV  = 3'd3;
    localparam logic [2:0] c_ST_FIN   = 3'd4;

    localparam logic [3:0] c_SEG_IF       = 4'd0;
    localparam logic [3:0] c_SEG_COND_VAR = 4'd1;
    localparam logic [3:0] c_SEG_OP       = 4'd2;
    localparam logic [3:0] c_SEG_COND_VAL = 4'd3;
    localparam logic [3:0] c_SEG_BEGIN_T  = 4'd4;
    localparam logic [3:0] c_SEG_ASG_T    = 4'd5;
    localparam logic [3:0] c_SEG_LE_T     = 4'd6;
    localparam logic [3:0] c_SEG_THEN_VAL = 4'd7;
    localparam logic [3:0] c_SEG_END_T    = 4'd8;
    localparam logic [3:0] c_SEG_ELSE     = 4'd9;
    localparam logic [3:0] c_SEG_BEGIN_E  = 4'd10;
    localparam logic [3:0] c_SEG_ASG_E    = 4'd11;
    localparam logic [3:0] c_SEG_LE_E     = 4'd12;
    localparam logic [3:0] c_SEG_ELSE_VAL = 4'd13;
    localparam logic [3:0] c_SEG_END_E    = 4'd14;

    // Up to six characters, right-justified: first character in the highest used byte.
    typedef logic [47:0] str6_t;

    typedef struct packed {
        logic [3:0]  cond_len;
        logic [2:0]  cond_op;
        logic [31:0] cond_val;
        logic [3:0]  asg_len;
        logic [31:0] then_val;
        logic [31:0] else_val;
    } stmt_req_t;

    function automatic str6_t seg_str(input logic [3:0] seg);
        str6_t s;
        case (seg)
            c_SEG_IF:                 s = str6_t'("if(");
            c_SEG_BEGIN_T:            s = str6_t'(")begin");
            c_SEG_LE_T, c_SEG_LE_E:   s = str6_t'("<=");
            c_SEG_END_T, c_SEG_END_E: s = str6_t'(";end");
            c_SEG_ELSE:               s = str6_t'("else");
            c_SEG_BEGIN_E:            s = str6_t'("begin");
            default:                  s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] seg_len(input logic [3:0] seg);
        logic [3:0] n;
        case (seg)
            c_SEG_IF:                 n = 4'd3;
            c_SEG_BEGIN_T:            n = 4'd6;
            c_SEG_LE_T, c_SEG_LE_E:   n = 4'd2;
            c_SEG_END_T, c_SEG_END_E: n = 4'd4;
            c_SEG_ELSE:               n = 4'd4;
            c_SEG_BEGIN_E:            n = 4'd5;
            default:                  n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic str6_t op_str(input logic [2:0] op);
        str6_t s;
        case (op)
            c_OP_GT: s = str6_t'(">");
            c_OP_LT: s = str6_t'("<");
            c_OP_GE: s = str6_t'(">=");
            c_OP_LE: s = str6_t'("<=");
            c_OP_EQ: s = str6_t'("==");
            c_OP_NE: s = str6_t'("!=");
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] op_len(input logic [2:0] op);
        return (op == c_OP_GT || op == c_OP_LT) ? 4'd1 : 4'd2;
    endfunction

    function automatic logic [c_CHAR_W-1:0] str_char(input str6_t s, input logic [3:0] len,
                                                     input logic [3:0] idx);
        logic [3:0] pos;
        pos = len - 4'd1 - idx;
        return s[{pos, 3'b000} +: c_CHAR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_else_stmt_gen_bin2dec_serial.sv
`default_nettype none
// ============================================================================
// Module   : bin2dec_serial
// Purpose  : 32-bit magnitude to 10-digit BCD, one double-dabble shift per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bin2dec_serial
    import if_else_defs::*;
(
    input  logic                      clk,
    input  logic                      rst,      // active low, synchronous
    input  logic                      i_start,
    input  logic [c_NUM_W-1:0]        i_bin,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [4*c_BCD_DIGITS-1:0] o_bcd
);

    logic [c_NUM_W-1:0]        r_bin;
    logic [4*c_BCD_DIGITS-1:0] r_bcd;
    logic [4:0]                r_cnt;
    logic                      r_busy;
    logic [4*c_BCD_DIGITS-1:0] w_adj;

    generate
        for (genvar g = 0; g < c_BCD_DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                                : r_bcd[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd  <= {w_adj[4*c_BCD_DIGITS-2:0], r_bin[c_NUM_W-1]};
            r_bin  <= {r_bin[c_NUM_W-2:0], 1'b0};
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Done marks the cycle of the final shift; o_bcd is complete the cycle after.
    assign o_done = r_busy && (r_cnt == 5'd31);
    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/if_else_stmt_gen.sv
`default_nettype none
// ============================================================================
// Module   : if_else_stmt_gen
// Purpose  : Serialises one Verilog if/else statement as an ASCII stream.
// Revision : 1.0 - initial release
// ============================================================================
module if_else_stmt_gen
    import if_else_defs::*;
#(
    parameter int MAX_VAR_LEN = c_MAX_VAR_LEN,
    parameter int CHAR_W      = c_CHAR_W
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MAX_VAR_LEN*CHAR_W-1:0] cond_var,
    input  logic [3:0]                    cond_var_length,
    input  logic [2:0]                    cond_op,
    input  logic signed [31:0]            cond_val,
    input  logic [MAX_VAR_LEN*CHAR_W-1:0] asg_var,
    input  logic [3:0]                    asg_var_length,
    input  logic signed [31:0]            then_val,
    input  logic signed [31:0]            else_val,
    output logic [CHAR_W-1:0]             ascii_char,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          error_flag,
    output logic [3:0]                    error_code
);

    logic [2:0]                    r_state;
    logic [3:0]                    r_seg;
    logic [3:0]                    r_idx;
    logic                          r_neg;
    logic                          r_err_flag;
    logic [3:0]                    r_err_code;
    stmt_req_t                     r_req;
    logic [MAX_VAR_LEN*CHAR_W-1:0] r_cond_var;
    logic [MAX_VAR_LEN*CHAR_W-1:0] r_asg_var;

    logic [31:0]                   w_num_val;
    logic [31:0]                   w_num_mag;
    logic                          w_b2d_start;
    logic                          w_b2d_busy;
    logic                          w_b2d_done;
    logic [4*c_BCD_DIGITS-1:0]     w_bcd;
    logic [3:0]                    w_msd;
    logic [3:0]                    w_num_len;
    logic [3:0]                    w_off;
    logic [3:0]                    w_pos;
    logic [3:0]                    w_digit;
    logic [c_CHAR_W-1:0]           w_num_char;
    logic [MAX_VAR_LEN*CHAR_W-1:0] w_var;
    logic [3:0]                    w_seg_len;
    logic [CHAR_W-1:0]             w_char;
    logic                          w_last;
    logic [3:0]                    w_next_seg;
    logic                          w_next_is_num;

    always_comb begin
        case (r_seg)
            c_SEG_COND_VAL: w_num_val = r_req.cond_val;
            c_SEG_THEN_VAL: w_num_val = r_req.then_val;
            default:        w_num_val = r_req.else_val;
        endcase
    end

    // Two's-complement negate also yields 2^31 correctly for the most negative value.
    assign w_num_mag   = w_num_val[31] ? (~w_num_val + 32'd1) : w_num_val;
    assign w_b2d_start = (r_state == c_ST_CONV) && !w_b2d_busy;

    bin2dec_serial u_bin2dec (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_b2d_start),
        .i_bin   (w_num_mag),
        .o_busy  (w_b2d_busy),
        .o_done  (w_b2d_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_msd = 4'd0;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_msd = 4'(i);
            end
        end
    end

    assign w_num_len  = {3'b000, r_neg} + w_msd + 4'd1;
    assign w_off      = r_idx - {3'b000, r_neg};
    assign w_pos      = w_msd - w_off;
    assign w_digit    = w_bcd[{w_pos, 2'b00} +: 4];
    assign w_num_char = (r_neg && (r_idx == 4'd0)) ? 7'h2D : (7'h30 + {3'b000, w_digit});

    assign w_var = (r_seg == c_SEG_COND_VAR) ? r_cond_var : r_asg_var;

    always_comb begin
        w_seg_len = seg_len(r_seg);
        w_char    = CHAR_W'(str_char(seg_str(r_seg), seg_len(r_seg), r_idx));
        case (r_seg)
            c_SEG_COND_VAR: begin
                w_seg_len = r_req.cond_len;
                w_char    = w_var[r_idx*CHAR_W +: CHAR_W];
            end
            c_SEG_ASG_T, c_SEG_ASG_E: begin
                w_seg_len = r_req.asg_len;
                w_char    = w_var[r_idx*CHAR_W +: CHAR_W];
            end
            c_SEG_OP: begin
                w_seg_len = op_len(r_req.cond_op);
                w_char    = CHAR_W'(str_char(op_str(r_req.cond_op), op_len(r_req.cond_op), r_idx));
            end
            c_SEG_COND_VAL, c_SEG_THEN_VAL, c_SEG_ELSE_VAL: begin
                w_seg_len = w_num_len;
                w_char    = CHAR_W'(w_num_char);
            end
            default: ;
        endcase
    end

    assign w_last        = (r_idx == w_seg_len - 4'd1);
    assign w_next_seg    = r_seg + 4'd1;
    assign w_next_is_num = (w_next_seg == c_SEG_COND_VAL) || (w_next_seg == c_SEG_THEN_VAL) ||
                           (w_next_seg == c_SEG_ELSE_VAL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_seg      <= c_SEG_IF;
            r_idx      <= 4'd0;
            r_neg      <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state    <= c_ST_CHECK;
                        r_err_flag <= 1'b0;
                        r_err_code <= c_ERR_NONE;
                    end
                end
                c_ST_CHECK: begin
                    if ((r_req.cond_len == 4'd0) || (r_req.asg_len == 4'd0)) begin
                        r_state    <= c_ST_IDLE;
                        r_err_flag <= 1'b1;
                        r_err_code <= c_ERR_LEN;
                    end else if (r_req.cond_op > c_OP_NE) begin
                        r_state    <= c_ST_IDLE;
                        r_err_flag <= 1'b1;
                        r_err_code <= c_ERR_OP;
                    end else begin
                        r_state <= c_ST_EMIT;
                        r_seg   <= c_SEG_IF;
                        r_idx   <= 4'd0;
                    end
                end
                c_ST_EMIT: begin
                    if (char_ready) begin
                        if (!w_last) begin
                            r_idx <= r_idx + 4'd1;
                        end else if (r_seg == c_SEG_END_E) begin
                            r_state <= c_ST_FIN;
                        end else begin
                            r_seg <= w_next_seg;
                            r_idx <= 4'd0;
                            if (w_next_is_num) begin
                                r_state <= c_ST_CONV;
                            end
                        end
                    end
                end
                c_ST_CONV: begin
                    if (w_b2d_start) begin
                        r_neg <= w_num_val[31];
                    end
                    if (w_b2d_done) begin
                        r_state <= c_ST_EMIT;
                    end
                end
                c_ST_FIN: r_state <= c_ST_IDLE;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Request snapshot: later input changes cannot disturb a statement in flight.
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_IDLE) && start) begin
            r_req.cond_len <= cond_var_length;
            r_req.cond_op  <= cond_op;
            r_req.cond_val <= cond_val;
            r_req.asg_len  <= asg_var_length;
            r_req.then_val <= then_val;
            r_req.else_val <= else_val;
            r_cond_var     <= cond_var;
            r_asg_var      <= asg_var;
        end
    end

    assign ascii_char = (r_state == c_ST_EMIT) ? w_char : '0;
    assign char_valid = (r_state == c_ST_EMIT);
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_FIN);
    assign error_flag = r_err_flag;
    assign error_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_if_else_stmt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_else_stmt_gen
// Purpose  : Directed self-checking bench for if_else_stmt_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_else_stmt_gen;

    localparam int c_VW = 16 * 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [c_VW-1:0]   cond_var;
    logic [3:0]        cond_var_length;
    logic [2:0]        cond_op;
    logic signed [31:0] cond_val;
    logic [c_VW-1:0]   asg_var;
    logic [3:0]        asg_var_length;
    logic signed [31:0] then_val;
    logic signed [31:0] else_val;
    logic [6:0]        ascii_char;
    logic              char_valid;
    logic              char_ready;
    logic              busy;
    logic              done;
    logic              error_flag;
    logic [3:0]        error_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_else_stmt_gen #(.MAX_VAR_LEN(16), .CHAR_W(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cond_var        (cond_var),
        .cond_var_length (cond_var_length),
        .cond_op         (cond_op),
        .cond_val        (cond_val),
        .asg_var         (asg_var),
        .asg_var_length  (asg_var_length),
        .then_val        (then_val),
        .else_val        (else_val),
        .ascii_char      (ascii_char),
        .char_valid      (char_valid),
        .char_ready      (char_ready),
        .busy            (busy),
        .done            (done),
        .error_flag      (error_flag),
        .error_code      (error_code)
    );

    task automatic chk(input string tag, input string obs, input string exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    function automatic logic [c_VW-1:0] pack(input string s);
        logic [c_VW-1:0] v;
        byte             b;
        v = '0;
        for (int i = 0; i < s.len() && i < 16; i++) begin
            b = s[i];
            v[7*i +: 7] = b[6:0];
        end
        return v;
    endfunction

    task automatic set_req(input string cv, input int cl, input int op, input int cval,
                           input string av, input int al, input int tv, input int ev);
        cond_var        = pack(cv);
        cond_var_length = 4'(cl);
        cond_op         = 3'(op);
        cond_val        = cval;
        asg_var         = pack(av);
        asg_var_length  = 4'(al);
        then_val        = tv;
        else_val        = ev;
    endtask

    task automatic scramble();
        set_req("qqqq", 0, 7, 999, "zz", 0, 7, 8);
    endtask

    task automatic run_stmt(input bit toggle, input int max_cyc, input int abort_at,
                            output string s, output int ndone, output int nlow,
                            output int nbad, output int nvalid);
        logic [6:0] held;
        bit         held_v;
        bit         seen;
        bit         fin;
        s = ""; ndone = 0; nlow = 0; nbad = 0; nvalid = 0;
        held = '0; held_v = 1'b0; seen = 1'b0; fin = 1'b0;
        @(posedge clk); #1; start = 1'b1; char_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0; scramble();
        for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
            @(negedge clk);
            if (char_valid) begin
                nvalid++;
                if (held_v && (ascii_char != held)) nbad++;
                if (abort_at > 0 && s.len() == abort_at - 1) begin
                    rst = 1'b0;
                    fin = 1'b1;
                end else if (char_ready) begin
                    s = $sformatf("%s%c", s, ascii_char);
                    seen = 1'b1;
                end
            end else if (seen && busy && !done) begin
                nlow++;
            end
            held_v = char_valid && !char_ready;
            held   = ascii_char;
            if (done) begin
                ndone++;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (toggle) char_ready = !char_ready;
                start = (cyc == 20);
            end
        end
        start = 1'b0;
        char_ready = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk(tag, $sformatf("busy=%0d done=%0d valid=%0d", busy, done, char_valid),
            "busy=0 done=0 valid=0");
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        string s;
        string exp;
        string ops [6];
        int    nd, nl, nb, nv;
        ops = '{">", "<", ">=", "<=", "==", "!="};

        rst = 1'b0; start = 1'b0; char_ready = 1'b0;
        set_req("", 0, 0, 0, "", 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", $sformatf("a=%0d v=%0d b=%0d d=%0d e=%0d c=%0d", ascii_char, char_valid,
            busy, done, error_flag, error_code), "a=0 v=0 b=0 d=0 e=0 c=0");
        @(posedge clk); #1; rst = 1'b1;

        // Main vector, sink always ready
        set_req("counter", 7, 2, 5, "result", 6, -201, -30);
        run_stmt(1'b0, 400, 0, s, nd, nl, nb, nv);
        chk("v1_stream", s, "if(counter>=5)beginresult<=-201;endelsebeginresult<=-30;end");
        chk("v1_len", $sformatf("%0d", s.len()), "59");
        chk("v1_done", $sformatf("%0d", nd), "1");
        chk("v1_conv_cycles", $sformatf("%0d", nl), "99");
        chk_idle("v1_idle");

        // Same vector with char_ready toggling every cycle
        set_req("counter", 7, 2, 5, "result", 6, -201, -30);
        run_stmt(1'b1, 600, 0, s, nd, nl, nb, nv);
        chk("v2_stream", s, "if(counter>=5)beginresult<=-201;endelsebeginresult<=-30;end");
        chk("v2_stall_stable", $sformatf("%0d", nb), "0");
        chk("v2_done", $sformatf("%0d", nd), "1");
        chk("v2_conv_cycles", $sformatf("%0d", nl), "99");
        chk_idle("v2_idle");

        // Numeric extremes
        set_req("counter", 7, 2, 0, "result", 6, 32'h8000_0000, 32'h7FFF_FFFF);
        run_stmt(1'b0, 400, 0, s, nd, nl, nb, nv);
        chk("v3_stream", s,
            "if(counter>=0)beginresult<=-2147483648;endelsebeginresult<=2147483647;end");
        chk("v3_done", $sformatf("%0d", nd), "1");

        // Shortest and longest variable names, ten-digit and zero values
        set_req("x", 1, 4, -7, "abcdefghijklmno", 15, 1000000000, 0);
        run_stmt(1'b0, 400, 0, s, nd, nl, nb, nv);
        chk("v4_stream", s,
            "if(x==-7)beginabcdefghijklmno<=1000000000;endelsebeginabcdefghijklmno<=0;end");

        // Every operator
        for (int k = 0; k < 6; k++) begin
            set_req("a", 1, k, 10, "b", 1, 1, -1);
            run_stmt(1'b0, 300, 0, s, nd, nl, nb, nv);
            exp = {"if(a", ops[k], "10)beginb<=1;endelsebeginb<=-1;end"};
            chk($sformatf("op%0d_stream", k), s, exp);
        end

        // Length error wins over operator error
        set_req("counter", 7, 7, 5, "result", 0, 1, 2);
        run_stmt(1'b0, 8, 0, s, nd, nl, nb, nv);
        chk("err1_flags", $sformatf("flag=%0d code=%0d", error_flag, error_code), "flag=1 code=1");
        chk("err1_no_chars", $sformatf("valid=%0d done=%0d", nv, nd), "valid=0 done=0");
        chk("err1_busy", $sformatf("%0d", busy), "0");

        set_req("counter", 7, 6, 5, "result", 6, 1, 2);
        run_stmt(1'b0, 8, 0, s, nd, nl, nb, nv);
        chk("err2_flags", $sformatf("flag=%0d code=%0d", error_flag, error_code), "flag=1 code=2");
        chk("err2_no_chars", $sformatf("valid=%0d done=%0d", nv, nd), "valid=0 done=0");

        set_req("", 0, 1, 5, "r", 1, 1, 2);
        run_stmt(1'b0, 8, 0, s, nd, nl, nb, nv);
        chk("err3_flags", $sformatf("flag=%0d code=%0d", error_flag, error_code), "flag=1 code=1");

        set_req("a", 1, 0, 3, "b", 1, 4, 5);
        run_stmt(1'b0, 300, 0, s, nd, nl, nb, nv);
        chk("err_clear", $sformatf("flag=%0d code=%0d", error_flag, error_code), "flag=0 code=0");
        chk("err_clear_stream", s, "if(a>3)beginb<=4;endelsebeginb<=5;end");

        // Reset while the tenth character is on the bus
        set_req("counter", 7, 2, 5, "result", 6, -201, -30);
        run_stmt(1'b0, 400, 10, s, nd, nl, nb, nv);
        chk("rst_partial", s, "if(counte");
        @(posedge clk); #1;
        chk("rst_mid", $sformatf("a=%0d v=%0d b=%0d d=%0d e=%0d c=%0d", ascii_char, char_valid,
            busy, done, error_flag, error_code), "a=0 v=0 b=0 d=0 e=0 c=0");
        rst = 1'b1;
        set_req("counter", 7, 2, 5, "result", 6, -201, -30);
        run_stmt(1'b0, 400, 0, s, nd, nl, nb, nv);
        chk("rst_restart", s, "if(counter>=5)beginresult<=-201;endelsebeginresult<=-30;end");
        chk("rst_restart_done", $sformatf("%0d", nd), "1");
        chk_idle("rst_restart_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
